// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM driving the shared-memory datapath (PC, IR, MDR, A/B, ALUOut).
// Each instruction takes 3-5 cycles; memory phases optionally wait on mem_ready.
module multicycle_control #(
  parameter int FUNCT_W = 6,
  parameter bit MEM_HS  = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               zero,
  input  logic               neg,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic [2:0]         pc_src,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic               illegal_op,
  output logic [CNT_W-1:0]   instr_count,
  output logic [3:0]         state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_IEXEC  = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_JMRD   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_JM    = 6'd16;
  localparam logic [5:0] OP_BALZ  = 6'd26;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_BGEZ  = 6'd39;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] FN_BRN   = 6'h15;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             retire_s;
  logic             ready_s;
  logic             brn_s;

  assign ready_s     = mem_ready | ~MEM_HS;
  assign brn_s       = (funct[5:0] == FN_BRN);
  assign count_d     = retire_s ? count_q + CNT_W'(1) : count_q;
  assign instr_count = count_q;
  assign state_dbg   = state_q;

  // Next-state and control decode; reset forces every output low whatever the state.
  always_comb begin
    state_d    = S_FETCH;
    retire_s   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 3'b000;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    illegal_op = 1'b0;
    if (reset) begin
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          if (ready_s) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          case (opcode)
            OP_LW, OP_SW, OP_JM:    state_d = S_MEMADR;
            OP_RTYPE:               state_d = S_EXEC;
            OP_ANDI:                state_d = S_IEXEC;
            OP_BEQ, OP_BGEZ, OP_BALZ: state_d = S_BRANCH;
            OP_J:                   state_d = S_JUMP;
            default: begin
              illegal_op = 1'b1;
              state_d    = S_FETCH;
            end
          endcase
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          if (opcode == OP_SW) begin
            state_d = S_MEMWR;
          end else if (opcode == OP_LW || opcode == OP_JM) begin
            state_d = S_MEMRD;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
          if (!ready_s) begin
            state_d = S_MEMRD;
          end else if (opcode == OP_JM) begin
            state_d = S_JMRD;
          end else if (opcode == OP_LW) begin
            state_d = S_MEMWB;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 2'b01;
          retire_s   = 1'b1;
        end
        S_MEMWR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
          if (ready_s) begin
            retire_s = 1'b1;
          end else begin
            state_d = S_MEMWR;
          end
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
          // brn retires here: jump to rs when the ALU result is negative
          if (brn_s) begin
            pc_src   = 3'b011;
            pc_write = neg;
            retire_s = 1'b1;
          end else begin
            state_d = S_RWB;
          end
        end
        S_RWB: begin
          reg_write = 1'b1;
          reg_dst   = 2'b01;
          retire_s  = 1'b1;
        end
        S_IEXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = 2'b11;
          state_d   = S_IWB;
        end
        S_IWB: begin
          reg_write = 1'b1;
          retire_s  = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b01;
          pc_src    = 3'b001;
          retire_s  = 1'b1;
          case (opcode)
            OP_BEQ:  pc_write = zero;
            OP_BGEZ: pc_write = ~neg;
            OP_BALZ: begin
              pc_write   = zero;
              reg_write  = zero;
              reg_dst    = 2'b10;
              mem_to_reg = 2'b10;
            end
            default: pc_write = 1'b0;
          endcase
        end
        S_JUMP: begin
          pc_write = 1'b1;
          pc_src   = 3'b010;
          retire_s = 1'b1;
        end
        S_JMRD: begin
          pc_write = 1'b1;
          pc_src   = 3'b100;
          retire_s = 1'b1;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  // State register and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: an instruction-level model predicts the phase
// sequence, per-phase controls and retire count for a handshaking and a non-handshaking DUT.
module tb_multicycle_control;

  typedef struct packed {
    logic       pc_write;
    logic [2:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal_op;
  } ctl_t;

  typedef int seq_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_s [2];
  logic [5:0] opc_s   [2];
  logic [5:0] fn_s    [2];
  logic       zero_s  [2];
  logic       neg_s   [2];
  logic       rdy_s   [2];
  wire [18:0] out_w   [2];
  wire [3:0]  st_w    [2];
  wire [15:0] cnt0_w;
  wire [3:0]  cnt1_w;

  int n_vec = 0;
  int n_err = 0;
  int cnt_m [2];

  multicycle_control #(.FUNCT_W(6), .MEM_HS(1'b1), .CNT_W(16)) dut_hs (
    .clk(clk), .reset(reset_s[0]), .opcode(opc_s[0]), .funct(fn_s[0]),
    .zero(zero_s[0]), .neg(neg_s[0]), .mem_ready(rdy_s[0]),
    .pc_write(out_w[0][18]), .pc_src(out_w[0][17:15]), .iord(out_w[0][14]),
    .mem_read(out_w[0][13]), .mem_write(out_w[0][12]), .ir_write(out_w[0][11]),
    .reg_dst(out_w[0][10:9]), .mem_to_reg(out_w[0][8:7]), .reg_write(out_w[0][6]),
    .alu_src_a(out_w[0][5]), .alu_src_b(out_w[0][4:3]), .alu_op(out_w[0][2:1]),
    .illegal_op(out_w[0][0]), .instr_count(cnt0_w), .state_dbg(st_w[0])
  );

  multicycle_control #(.FUNCT_W(6), .MEM_HS(1'b0), .CNT_W(4)) dut_nh (
    .clk(clk), .reset(reset_s[1]), .opcode(opc_s[1]), .funct(fn_s[1]),
    .zero(zero_s[1]), .neg(neg_s[1]), .mem_ready(rdy_s[1]),
    .pc_write(out_w[1][18]), .pc_src(out_w[1][17:15]), .iord(out_w[1][14]),
    .mem_read(out_w[1][13]), .mem_write(out_w[1][12]), .ir_write(out_w[1][11]),
    .reg_dst(out_w[1][10:9]), .mem_to_reg(out_w[1][8:7]), .reg_write(out_w[1][6]),
    .alu_src_a(out_w[1][5]), .alu_src_b(out_w[1][4:3]), .alu_op(out_w[1][2:1]),
    .illegal_op(out_w[1][0]), .instr_count(cnt1_w), .state_dbg(st_w[1])
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] opc);
    return (opc == 6'd0) || (opc == 6'd2) || (opc == 6'd4) || (opc == 6'd12) || (opc == 6'd16) ||
           (opc == 6'd26) || (opc == 6'd35) || (opc == 6'd39) || (opc == 6'd43);
  endfunction

  // Phase sequence an instruction walks through, ignoring memory stalls.
  function automatic seq_t path_of(input logic [5:0] opc, input logic [5:0] fn);
    case (opc)
      6'd35:  return '{0, 1, 2, 3, 4};
      6'd43:  return '{0, 1, 2, 5};
      6'd16:  return '{0, 1, 2, 3, 12};
      6'd0:   return (fn == 6'h15) ? '{0, 1, 6} : '{0, 1, 6, 7};
      6'd12:  return '{0, 1, 8, 9};
      6'd4, 6'd39, 6'd26: return '{0, 1, 10};
      6'd2:   return '{0, 1, 11};
      default: return '{0, 1};
    endcase
  endfunction

  // Controls expected in a given phase of a given instruction.
  function automatic ctl_t exp_ctl(input int ph, input logic [5:0] opc, input logic [5:0] fn,
                                   input logic z, input logic n, input logic rdy);
    ctl_t c;
    c = '0;
    case (ph)
      0:  begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
      1:  begin c.alu_src_b = 2'b11; c.illegal_op = !is_legal(opc); end
      2:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      3:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
      4:  begin c.reg_write = 1'b1; c.mem_to_reg = 2'b01; end
      5:  begin c.mem_write = 1'b1; c.iord = 1'b1; end
      6:  begin
            c.alu_src_a = 1'b1; c.alu_op = 2'b10;
            if (fn == 6'h15) begin c.pc_src = 3'b011; c.pc_write = n; end
          end
      7:  begin c.reg_write = 1'b1; c.reg_dst = 2'b01; end
      8:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = 2'b11; end
      9:  c.reg_write = 1'b1;
      10: begin
            c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_src = 3'b001;
            if (opc == 6'd4) c.pc_write = z;
            if (opc == 6'd39) c.pc_write = !n;
            if (opc == 6'd26) begin
              c.pc_write = z; c.reg_write = z; c.reg_dst = 2'b10; c.mem_to_reg = 2'b10;
            end
          end
      11: begin c.pc_write = 1'b1; c.pc_src = 3'b010; end
      12: begin c.pc_write = 1'b1; c.pc_src = 3'b100; end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic int cnt_obs(input int k);
    return (k == 0) ? int'(cnt0_w) : int'(cnt1_w);
  endfunction

  function automatic int cnt_mask(input int k);
    return (k == 0) ? 32'hFFFF : 32'hF;
  endfunction

  // Drive one instruction into DUT k; stop_idx >= 0 abandons it on reaching that phase.
  task automatic run_instr(input int k, input logic [5:0] opc, input logic [5:0] fn, input int stop_idx);
    seq_t seq;
    int   i;
    int   nstall;
    int   ph;
    logic rdy_eff;
    ctl_t ec;
    seq    = path_of(opc, fn);
    i      = 0;
    nstall = 0;
    while (i < seq.size() && i != stop_idx) begin
      @(negedge clk);
      reset_s[k] = 1'b0;
      opc_s[k]   = opc;
      fn_s[k]    = fn;
      zero_s[k]  = 1'($urandom_range(0, 1));
      neg_s[k]   = 1'($urandom_range(0, 1));
      rdy_s[k]   = (nstall >= 4) ? 1'b1 : 1'($urandom_range(0, 2) != 0);
      #1;
      ph      = seq[i];
      rdy_eff = (k == 0) ? rdy_s[k] : 1'b1;
      ec      = exp_ctl(ph, opc, fn, zero_s[k], neg_s[k], rdy_eff);
      chk_eq("state", 32'(st_w[k]), 32'(ph));
      chk_eq("ctl", 32'(out_w[k]), 32'(ec));
      if ((ph == 0 || ph == 3 || ph == 5) && !rdy_eff) begin
        nstall++;
      end else begin
        nstall = 0;
        i++;
        if (i == seq.size() && is_legal(opc)) cnt_m[k] = (cnt_m[k] + 1) & cnt_mask(k);
      end
      @(posedge clk);
      #1;
      chk_eq("count", 32'(cnt_obs(k)), 32'(cnt_m[k]));
    end
  endtask

  // Hold reset for n cycles, checking every strobe is low; first_st is the state seen in cycle one.
  task automatic do_reset(input int k, input int n, input int first_st);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      reset_s[k] = 1'b1;
      rdy_s[k]   = 1'($urandom_range(0, 1));
      #1;
      chk_eq("rst_ctl", 32'(out_w[k]), 32'd0);
      chk_eq("rst_state", 32'(st_w[k]), (c == 0) ? 32'(first_st) : 32'd0);
    end
    @(posedge clk);
    #1;
    cnt_m[k] = 0;
    chk_eq("rst_count", 32'(cnt_obs(k)), 32'd0);
  endtask

  task automatic random_instr(input int k);
    logic [5:0] opc;
    logic [5:0] fn;
    int sel;
    sel = $urandom_range(0, 10);
    case (sel)
      0: opc = 6'd35;  1: opc = 6'd43;  2: opc = 6'd16;  3: opc = 6'd0;
      4: opc = 6'd12;  5: opc = 6'd4;   6: opc = 6'd39;  7: opc = 6'd26;
      8: opc = 6'd2;   9: opc = 6'd0;
      default: opc = 6'($urandom_range(0, 63));
    endcase
    fn = ($urandom_range(0, 3) == 0) ? 6'h15 : 6'($urandom_range(0, 63));
    run_instr(k, opc, fn, -1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      reset_s[k] = 1'b1; opc_s[k] = 6'd0; fn_s[k] = 6'd0;
      zero_s[k] = 1'b0; neg_s[k] = 1'b0; rdy_s[k] = 1'b0; cnt_m[k] = 0;
    end
    do_reset(0, 2, 0);
    run_instr(0, 6'd35, 6'h00, -1);
    run_instr(0, 6'd0,  6'h20, -1);
    run_instr(0, 6'd43, 6'h00, -1);
    run_instr(0, 6'd4,  6'h00, -1);
    run_instr(0, 6'd4,  6'h00, -1);
    run_instr(0, 6'd26, 6'h00, -1);
    run_instr(0, 6'd39, 6'h00, -1);
    run_instr(0, 6'd0,  6'h15, -1);
    run_instr(0, 6'd16, 6'h00, -1);
    run_instr(0, 6'd12, 6'h00, -1);
    run_instr(0, 6'd2,  6'h00, -1);
    run_instr(0, 6'h3F, 6'h00, -1);
    run_instr(0, 6'd35, 6'h00, 3);
    do_reset(0, 2, 3);
    for (int t = 0; t < 150; t++) random_instr(0);
    reset_s[0] = 1'b1;

    do_reset(1, 2, 0);
    run_instr(1, 6'd35, 6'h00, -1);
    run_instr(1, 6'd0,  6'h20, -1);
    for (int t = 0; t < 17; t++) run_instr(1, 6'd2, 6'h00, -1);
    run_instr(1, 6'h3F, 6'h00, -1);
    for (int t = 0; t < 150; t++) random_instr(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
